// File: rtl/ppu_out_packer.sv
// Packs PPU output bytes little-endian into 32-bit words, buffers them in a
// small word FIFO and writes them to the output buffer at auto-incrementing addresses.
module ppu_out_packer #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_bytes,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PACK, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] word_idx;
  logic [15:0]       num_q;
  logic [15:0]       byte_cnt;
  logic [1:0]        lane;
  logic [31:0]       pack_data;
  logic [3:0]        pack_strb;

  logic [35:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;

  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              last_byte;
  logic              push;
  logic              pop;
  logic [31:0]       merged_data;
  logic [3:0]        merged_strb;

  always_comb begin
    fifo_full   = (count == (PW+1)'(FIFO_DEPTH));
    fifo_empty  = (count == '0);
    in_ready    = (state == PACK) && !fifo_full;
    accept      = in_valid && in_ready;
    last_byte   = ((byte_cnt + 16'd1) == num_q);
    push        = accept && ((lane == 2'd3) || last_byte);
    merged_data = pack_data | ({24'd0, in_data} << {lane, 3'b000});
    merged_strb = pack_strb | (4'b0001 << lane);
    wr_en       = !fifo_empty;
    pop         = wr_en && wr_ready;
    // head is masked while empty so the write bus reads 0 without resetting storage
    wr_data     = fifo_empty ? '0 : mem[rd_ptr][35:4];
    wr_strb     = fifo_empty ? '0 : mem[rd_ptr][3:0];
    wr_addr     = base_q + word_idx;
    busy        = (state != IDLE);
    done        = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {merged_data, merged_strb};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base_q    <= '0;
      num_q     <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      lane      <= '0;
      pack_data <= '0;
      pack_strb <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      if (in_valid && !in_ready) err <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            num_q     <= num_bytes;
            err       <= 1'b0;
            byte_cnt  <= '0;
            lane      <= '0;
            word_idx  <= '0;
            pack_data <= '0;
            pack_strb <= '0;
            state     <= (num_bytes == 16'd0) ? DONE : PACK;
          end
        end
        PACK: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 16'd1;
            lane     <= lane + 2'd1;
            if (push) begin
              pack_data <= '0;
              pack_strb <= '0;
            end else begin
              pack_data <= merged_data;
              pack_strb <= merged_strb;
            end
            if (last_byte) state <= DRAIN;
          end
        end
        DRAIN: begin
          // leave in the cycle of the final handshake so done follows it directly
          if (fifo_empty || ((count == (PW+1)'(1)) && pop)) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        word_idx <= word_idx + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_out_packer.sv
// Scoreboard bench for ppu_out_packer: expected writes are queued at job start
// and a negedge monitor compares every presented write against the queue head.
module tb_ppu_out_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] num_bytes;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_ready;
  logic        busy;
  logic        done;
  logic        err;

  ppu_out_packer #(.ADDR_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_bytes(num_bytes),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_ready(wr_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim [64];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         last_hs_cyc = 0;
  int         start_cyc = 0;
  int         acc_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (in_valid && in_ready) acc_cnt = acc_cnt + 1;
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(wr_en), 64'd0);
        end else begin
          e = exp_q[0];
          chk("wr_addr", 64'(wr_addr), 64'(e.addr));
          chk("wr_data", 64'(wr_data), 64'(e.data));
          chk("wr_strb", 64'(wr_strb), 64'(e.strb));
          if (wr_ready) begin
            e = exp_q.pop_front();
            last_hs_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic pulse_start(input logic [15:0] b, input logic [15:0] n);
    base_addr = b;
    num_bytes = n;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic start_job(input logic [15:0] b, input int n);
    wr_t w;
    for (int wi = 0; wi < (n + 3) / 4; wi++) begin
      w.addr = b + 16'(wi);
      w.data = '0;
      w.strb = '0;
      for (int l = 0; l < 4; l++) begin
        if (wi * 4 + l < n) begin
          w.data[8*l +: 8] = stim[wi * 4 + l];
          w.strb[l]        = 1'b1;
        end
      end
      exp_q.push_back(w);
    end
    done_cnt = 0;
    acc_cnt  = 0;
    pulse_start(b, 16'(n));
  endtask

  task automatic feed(input int n, input bit gate);
    int idx = 0;
    int k = 0;
    while (idx < n && k < 2000) begin
      in_data  = stim[idx];
      in_valid = gate ? in_ready : 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    chk("feed_complete", 64'(idx), 64'(n));
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_cnt == 0 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_timeout", 64'(done_cnt > 0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", 64'(done_cnt), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_wr_en"},    64'(wr_en),    64'd0);
    chk({tag, "_wr_addr"},  64'(wr_addr),  64'd0);
    chk({tag, "_wr_data"},  64'(wr_data),  64'd0);
    chk({tag, "_wr_strb"},  64'(wr_strb),  64'd0);
    chk({tag, "_busy"},     64'(busy),     64'd0);
    chk({tag, "_done"},     64'(done),     64'd0);
    chk({tag, "_err"},      64'(err),      64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_bytes = '0;
    in_data = '0; in_valid = 1'b0; wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // 16 bytes, full words, no backpressure
    for (int i = 0; i < 16; i++) stim[i] = 8'(i);
    start_job(16'h0100, 16);
    feed(16, 1'b1);
    wait_done();
    chk("t1_done_after_last_write", 64'(done_cyc - last_hs_cyc), 64'd1);
    chk("t1_err", 64'(err), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);

    // partial final word
    for (int i = 0; i < 6; i++) stim[i] = 8'hA1 + 8'(i);
    start_job(16'h0200, 6);
    feed(6, 1'b1);
    wait_done();
    chk("t2_done_after_last_write", 64'(done_cyc - last_hs_cyc), 64'd1);

    // 20-cycle write stall, gated valid, address wrap past 0xFFFF
    for (int i = 0; i < 32; i++) stim[i] = 8'h40 + 8'(i);
    wr_ready = 1'b0;
    start_job(16'hFFFE, 32);
    fork
      feed(32, 1'b1);
      begin
        repeat (20) @(posedge clk);
        #1;
        chk("t3_bytes_before_full", 64'(acc_cnt), 64'd16);
        chk("t3_in_ready_full", 64'(in_ready), 64'd0);
        wr_ready = 1'b1;
      end
    join
    wait_done();
    chk("t3_err", 64'(err), 64'd0);

    // ungated valid into a full FIFO: dropped bytes set err but are re-offered
    for (int i = 0; i < 20; i++) stim[i] = 8'h80 + 8'(i);
    wr_ready = 1'b0;
    start_job(16'h0400, 20);
    fork
      feed(20, 1'b0);
      begin
        repeat (24) @(posedge clk);
        #1;
        chk("t4_err_set", 64'(err), 64'd1);
        chk("t4_bytes_before_full", 64'(acc_cnt), 64'd16);
        wr_ready = 1'b1;
      end
    join
    wait_done();
    chk("t4_err_sticky", 64'(err), 64'd1);

    // zero-length job: done only, start clears err
    start_job(16'h0500, 0);
    chk("t5_err_cleared", 64'(err), 64'd0);
    wait_done();
    chk("t5_done_latency", 64'(done_cyc - start_cyc), 64'd1);

    // start while busy is ignored
    for (int i = 0; i < 8; i++) stim[i] = 8'hC0 + 8'(i);
    start_job(16'h0600, 8);
    pulse_start(16'h0777, 16'd0);
    feed(8, 1'b1);
    wait_done();

    // asynchronous reset mid-job, then a clean job
    for (int i = 0; i < 16; i++) stim[i] = 8'h10 + 8'(i);
    start_job(16'h0300, 16);
    feed(5, 1'b1);
    chk("t6_busy_before_rst", 64'(busy), 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("t6_rst");
    exp_q.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) stim[i] = 8'h50 + 8'(i);
    start_job(16'h0040, 8);
    feed(8, 1'b1);
    wait_done();
    chk("t6_err", 64'(err), 64'd0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
